// File: rtl/biu_bus_arbiter_pkg.sv
// Shared definitions for the BIU bus arbiter: FSM state encoding, BIU op codes
// and the default abort timeout.
package biu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_WAITREL = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LDST  = 2'b01;

    localparam int unsigned TIMEOUT_CYC_DEF = 15;

endpackage

// File: rtl/biu_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', modulo NREQ.
// Returns a one-hot winner, its binary index and a found flag.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    int unsigned cand;

    // Offsets 1..NREQ visit last+1 first and last itself at the very end.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last) + k) % NREQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/biu_bus_arbiter.sv
// Round-robin arbiter sharing the single BIU between NREQ requesters; all outputs
// registered. Optional BUSY-state abort timeout enabled by macro ARB_TIMEOUT_EN.
module biu_bus_arbiter
    import biu_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned IDW         = 2,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic              ready_bus,
    output logic              cs_biu,
    output logic [1:0]        sel_biu,
    output logic [NREQ-1:0]   gnt,
    output logic [IDW-1:0]    gnt_id,
    output logic              busy,
    output logic [NREQ-1:0]   done,
    output logic              err
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [1:0]      sel_q, sel_d;
    logic            cs_q, cs_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IDW-1:0]  pick_idx;
    logic            pick_found;
    logic [1:0]      pick_op;
    logic            timeout_hit;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req    (req),
        .last   (last_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        pick_op = OP_FETCH;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) pick_op = op[2*i +: 2];
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Count reaches TIMEOUT_CYC on the edge that leaves BUSY.
    assign timeout_hit = (state_q == ST_BUSY) && !ready_bus && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) cnt_d = '0;
        else if (state_q == ST_BUSY && !ready_bus) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        sel_d    = sel_q;
        cs_d     = cs_q;
        busy_d   = busy_q;
        done_d   = '0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d  = ST_BUSY;
                    gnt_d    = pick_onehot;
                    gnt_id_d = pick_idx;
                    sel_d    = pick_op;
                    cs_d     = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (ready_bus) begin
                    state_d = ST_WAITREL;
                    cs_d    = 1'b0;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    cs_d    = 1'b0;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = gnt_q;
                    last_d  = gnt_id_q;
                    err_d   = 1'b1;
                end
            end
            ST_WAITREL: begin
                if (!ready_bus) begin
                    state_d = ST_DONE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = gnt_q;
                    last_d  = gnt_id_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= IDW'(NREQ - 1);
            gnt_q    <= '0;
            gnt_id_q <= '0;
            sel_q    <= OP_FETCH;
            cs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            sel_q    <= sel_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cs_biu  = cs_q;
    assign sel_biu = sel_q;
    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// Directed self-checking bench for biu_bus_arbiter (NREQ=3); timeout expectations
// follow ARB_TIMEOUT_EN, which also selects TIMEOUT_CYC=4.
module tb_biu_bus_arbiter;
    import biu_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [5:0] op;
    logic       ready_bus;
    logic       cs_biu;
    logic [1:0] sel_biu;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [2:0] done;
    logic       err;

    int errors = 0;
    int checks = 0;

`ifdef ARB_TIMEOUT_EN
    biu_bus_arbiter #(.NREQ(3), .IDW(2), .TIMEOUT_CYC(4)) dut (
`else
    biu_bus_arbiter #(.NREQ(3), .IDW(2)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .ready_bus (ready_bus),
        .cs_biu    (cs_biu),
        .sel_biu   (sel_biu),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic c, input logic [1:0] s, input logic [2:0] g,
                           input logic [1:0] id, input logic b, input logic [2:0] d, input logic e);
        chk({tag, ".cs"},   32'(cs_biu),  32'(c));
        chk({tag, ".sel"},  32'(sel_biu), 32'(s));
        chk({tag, ".gnt"},  32'(gnt),     32'(g));
        chk({tag, ".id"},   32'(gnt_id),  32'(id));
        chk({tag, ".busy"}, 32'(busy),    32'(b));
        chk({tag, ".done"}, 32'(done),    32'(d));
        chk({tag, ".err"},  32'(err),     32'(e));
    endtask

    initial begin
        logic [1:0] order [6];
        order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        rst = 1'b1; req = '0; op = '0; ready_bus = 1'b0;
        tick(); tick();
        chk_all("reset", 1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("idle", 1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);

        // Single request from requester 1 with a load/store op
        req = 3'b010; op = {2'b00, OP_LDST, 2'b00};
        tick();
        chk_all("single.grant", 1'b1, 2'b01, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        op = '0;
        tick();
        chk_all("single.busy2", 1'b1, 2'b01, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        ready_bus = 1'b1;
        tick();
        chk_all("single.waitrel", 1'b0, 2'b01, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        ready_bus = 1'b0;
        tick();
        chk_all("single.done", 1'b0, 2'b01, 3'b000, 2'd1, 1'b0, 3'b010, 1'b0);
        req = 3'b000;
        tick();
        chk_all("single.after", 1'b0, 2'b01, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0);
        tick();
        chk("single.nodone2", 32'(done), 32'd0);

        // Reset asserted mid-BUSY with requester 1 granted
        req = 3'b010;
        tick();
        chk("rstmid.gnt", 32'(gnt), 32'b010);
        tick();
        rst = 1'b1;
        #1;
        chk_all("rstmid.async", 1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("rstmid.nodone", 32'(done), 32'd0);
        rst = 1'b0;
        req = 3'b111; op = {2'b00, OP_LDST, OP_FETCH};

        // Fairness with all three held; the first grant also shows the pointer was reset
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fair.gnt",  32'(gnt),    32'(3'b001 << order[i]));
            chk("fair.id",   32'(gnt_id), 32'(order[i]));
            chk("fair.sel",  32'(sel_biu), (order[i] == 2'd1) ? 32'd1 : 32'd0);
            ready_bus = 1'b1;
            tick();
            ready_bus = 1'b0;
            tick();
            chk("fair.done", 32'(done),   32'(3'b001 << order[i]));
            chk("fair.idkeep", 32'(gnt_id), 32'(order[i]));
            tick();
            chk("fair.doneclr", 32'(done), 32'd0);
        end
        req = 3'b000; op = '0;
        tick();

        // ready_bus held high for 5 cycles: stays in WAITREL, one done after release
        req = 3'b001;
        tick();
        chk("hold.gnt", 32'(gnt), 32'b001);
        ready_bus = 1'b1;
        tick();
        chk_all("hold.wr0", 1'b0, 2'b00, 3'b001, 2'd0, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("hold.wr", 1'b0, 2'b00, 3'b001, 2'd0, 1'b1, 3'b000, 1'b0);
        end
        ready_bus = 1'b0;
        tick();
        chk_all("hold.done", 1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 3'b001, 1'b0);
        req = 3'b000;
        tick();
        chk("hold.doneclr", 32'(done), 32'd0);

        // Requester 2 withdraws one cycle after grant; requester 0 pending
        req = 3'b100;
        tick();
        chk("wd.gnt2", 32'(gnt), 32'b100);
        chk("wd.id2", 32'(gnt_id), 32'd2);
        req = 3'b001;
        tick();
        chk("wd.busy", 32'(busy), 32'd1);
        ready_bus = 1'b1;
        tick();
        ready_bus = 1'b0;
        tick();
        chk("wd.done2", 32'(done), 32'b100);
        tick();
        tick();
        chk("wd.gnt0", 32'(gnt), 32'b001);
        chk("wd.id0", 32'(gnt_id), 32'd0);
        ready_bus = 1'b1;
        tick();
        ready_bus = 1'b0;
        req = 3'b000;
        tick();
        chk("wd.done0", 32'(done), 32'b001);
        tick();

        // Timeout: ready_bus never asserted
        req = 3'b010;
        tick();
        chk_all("tmo.grant", 1'b1, 2'b00, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("tmo.busy", 1'b1, 2'b00, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        chk_all("tmo.abort", 1'b0, 2'b00, 3'b000, 2'd1, 1'b0, 3'b010, 1'b1);
        req = 3'b000;
        tick();
        chk("tmo.errclr", 32'(err), 32'd0);
        chk("tmo.doneclr", 32'(done), 32'd0);
`else
        chk_all("tmo.nowait", 1'b1, 2'b00, 3'b010, 2'd1, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 45; i++) begin
            tick();
            chk("tmo.stillbusy", 32'(busy), 32'd1);
            chk("tmo.noerr", 32'(err), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
